// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage.
//   INSTR_W       : instruction word width
//   fetch_state_t : fetch FSM states (idle, request outstanding, holding an instruction)
package cpu_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (loads RESET_PC)
//   load       : take load_val (branch redirect); wins over inc
//   load_val   : redirect address
//   inc        : advance by one word, wrapping mod 2**ADDR_W
//   pc         : current next-fetch address
module pc_counter #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_r;

    // PC register: redirect has priority over sequential advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc_r <= load_val;
        end else if (inc) begin
            pc_r <= pc_r + ADDR_W'(1);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decoder.
// Keeps one read outstanding to instruction memory at a time (req/ack, variable
// latency), holds the returned word for decode under a valid/ready handshake,
// and handles branch redirects (squashing an in-flight read) and halt.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata    : instruction memory read port
//   instr/instr_pc/instr_valid : instruction offered to decode
//   instr_ready                : decode accepts (fire = instr_valid & instr_ready)
//   branch_en/branch_target    : one-cycle redirect pulse and its target
//   halt                       : level; blocks new requests only
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt
);

    fetch_state_t       state_r;
    logic [ADDR_W-1:0]  req_addr_r;
    logic [INSTR_W-1:0] instr_r;
    logic [ADDR_W-1:0]  instr_pc_r;
    logic               squash_r;

    logic [ADDR_W-1:0]  pc_s;
    logic [ADDR_W-1:0]  pc_next_s;
    logic               fire_s;
    logic               pc_inc_s;

    // A redirect in this cycle also steers any request started this cycle,
    // so the new request and the PC never disagree.
    assign pc_next_s = branch_en ? branch_target : pc_s;
    assign fire_s    = (state_r == S_HOLD) && instr_ready;
    // Only a clean (unsquashed, unredirected) return advances the PC; at that
    // point pc equals req_addr, so pc+1 is the following word.
    assign pc_inc_s  = (state_r == S_REQ) && imem_ack && !squash_r && !branch_en;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (branch_en),
        .load_val (branch_target),
        .inc      (pc_inc_s),
        .pc       (pc_s)
    );

    // Fetch FSM: request issue, response capture, squash tracking and hand-off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            req_addr_r <= ADDR_W'(RESET_PC);
            instr_r    <= '0;
            instr_pc_r <= '0;
            squash_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!halt) begin
                        state_r    <= S_REQ;
                        req_addr_r <= pc_next_s;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        if (squash_r || branch_en) begin
                            // Stale data from the old path: drop it and refetch
                            squash_r <= 1'b0;
                            if (!halt) begin
                                state_r    <= S_REQ;
                                req_addr_r <= pc_next_s;
                            end else begin
                                state_r    <= S_IDLE;
                            end
                        end else begin
                            instr_r    <= imem_rdata;
                            instr_pc_r <= req_addr_r;
                            state_r    <= S_HOLD;
                        end
                    end else if (branch_en) begin
                        // Request must stay up until ack; remember to discard it
                        squash_r <= 1'b1;
                    end else begin
                        squash_r <= squash_r;
                    end
                end
                S_HOLD: begin
                    // A branch drops the held word; if it coincides with fire
                    // the word still counts as consumed.
                    if (branch_en || fire_s) begin
                        if (!halt) begin
                            state_r    <= S_REQ;
                            req_addr_r <= pc_next_s;
                        end else begin
                            state_r    <= S_IDLE;
                        end
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    squash_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = (state_r == S_REQ);
    assign instr_valid = (state_r == S_HOLD);
    assign imem_addr   = req_addr_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;

endmodule
